// File: rtl/uart_bus_initiator.sv
// uart_bus_initiator: serialises local bus reads/writes into UART command frames for a remote bus master
// Ports: i_clk/i_reset (sync, active high); bus slave i_addr[15:0], i_data[7:0], i_we, i_cs -> o_ack, o_err, o_data[7:0];
//        serial link o_uart_tx (idle high) to the remote master, i_uart_rx for read replies.
// Frames: write 0x57,AH,AL,D (no reply); read 0x52,AH,AL then one reply byte or a timeout (o_data=0xFF, o_err=1).
module uart_bus_initiator #(
  parameter int BAUDRATE       = 115200,
  parameter int SYS_FREQ       = 2500000,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  output logic [7:0]  o_data,
  input  logic        i_we,
  input  logic        i_cs,
  output logic        o_ack,
  output logic        o_err,
  input  logic        i_uart_rx,
  output logic        o_uart_tx
);
  localparam int TICK = SYS_FREQ / BAUDRATE;
  localparam int TW   = $clog2(TICK + 1);
  localparam int CW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {IDLE, CMD, AH, AL, DAT, WDONE, RWAIT, ACK, RELEASE} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic          tx_start, tx_ready;
  logic [7:0]    tx_byte;
  logic [TW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic          tx_busy_q, tx_busy_d;

  logic          rx_received;
  logic [1:0]    rx_sync_q, rx_sync_d;
  rx_state_t     rx_st_q, rx_st_d;
  logic [TW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;

  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          sent_q, sent_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [7:0]    data_q, data_d;

  // Transmitter: 10-bit frame {stop, data, start} shifted out LSB first, one bit per TICK clocks.
  always_comb begin
    tx_ready  = !tx_busy_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_busy_d = tx_busy_q;
    if (tx_start && tx_ready) begin
      tx_sh_d   = {1'b1, tx_byte, 1'b0};
      tx_cnt_d  = '0;
      tx_bit_d  = '0;
      tx_busy_d = 1'b1;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == TW'(TICK - 1)) begin
        tx_cnt_d  = '0;
        tx_sh_d   = {1'b1, tx_sh_q[9:1]};
        tx_bit_d  = tx_bit_q + 4'd1;
        tx_busy_d = tx_bit_q != 4'd9;
      end else begin
        tx_cnt_d = tx_cnt_q + TW'(1);
      end
    end
  end

  assign o_uart_tx = tx_busy_q ? tx_sh_q[0] : 1'b1;

  // Receiver: start bit confirmed at mid-bit, then data sampled every TICK from there.
  always_comb begin
    rx_sync_d   = {rx_sync_q[0], i_uart_rx};
    rx_st_d     = rx_st_q;
    rx_cnt_d    = rx_cnt_q + TW'(1);
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_received = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_st_d  = rx_sync_q[1] ? RX_IDLE : RX_START;
      end
      RX_START: if (rx_cnt_q == TW'(TICK / 2 - 1)) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_sync_q[1] ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == TW'(TICK - 1)) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_sync_q[1], rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        rx_st_d  = rx_bit_q == 3'd7 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (rx_cnt_q == TW'(TICK - 1)) begin
        rx_received = rx_sync_q[1];
        rx_st_d     = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // Transaction sequencer. sent_q marks that the current byte was handed to the
  // transmitter, so each byte state issues exactly once and advances on tx_ready falling.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    sent_d   = sent_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    data_d   = data_q;
    tx_start = 1'b0;
    tx_byte  = state_q == CMD ? (we_q ? 8'h57 : 8'h52) :
               state_q == AH  ? addr_q[15:8] :
               state_q == AL  ? addr_q[7:0]  : wdata_q;
    case (state_q)
      IDLE: if (i_cs) begin
        addr_d  = i_addr;
        wdata_d = i_data;
        we_d    = i_we;
        err_d   = 1'b0;
        state_d = CMD;
      end
      CMD, AH, AL, DAT: begin
        tx_start = !sent_q && tx_ready;
        if (tx_start) begin
          sent_d = 1'b1;
        end else if (sent_q && !tx_ready) begin
          sent_d  = 1'b0;
          cnt_d   = '0;
          state_d = state_q == CMD ? AH :
                    state_q == AH  ? AL :
                    state_q == AL  ? (we_q ? DAT : RWAIT) : WDONE;
        end
      end
      WDONE: state_d = tx_ready ? ACK : WDONE;
      RWAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (rx_received) begin
          data_d  = rx_sh_q;
          state_d = ACK;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          data_d  = 8'hFF;
          err_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = RELEASE;
      RELEASE: state_d = i_cs ? RELEASE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_ack  = state_q == ACK;
  assign o_err  = o_ack && err_q;
  assign o_data = data_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '1;
      tx_busy_q <= 1'b0;
      rx_sync_q <= 2'b11;
      rx_st_q   <= RX_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      sent_q    <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_busy_q <= tx_busy_d;
      rx_sync_q <= rx_sync_d;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      sent_q    <= sent_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      data_q    <= data_d;
    end
  end
endmodule

// File: tb/tb_uart_bus_initiator.sv
// tb_uart_bus_initiator: scoreboard bench decoding the command stream and replying over UART
module tb_uart_bus_initiator;
  localparam int BAUD = 115200;
  localparam int FREQ = 2500000;
  localparam int TICK = FREQ / BAUD;
  localparam int TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_addr = '0;
  logic [7:0]  i_data = '0;
  logic [7:0]  o_data;
  logic        i_we = 1'b0;
  logic        i_cs = 1'b0;
  logic        o_ack, o_err;
  logic        rx = 1'b1;
  logic        o_uart_tx;

  uart_bus_initiator #(.BAUDRATE(BAUD), .SYS_FREQ(FREQ), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_reset(rst), .i_addr(i_addr), .i_data(i_data), .o_data(o_data),
    .i_we(i_we), .i_cs(i_cs), .o_ack(o_ack), .o_err(o_err),
    .i_uart_rx(rx), .o_uart_tx(o_uart_tx)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int bytes_seen = 0, acks_seen = 0, last_start = 0, last_ack = 0;
  logic [7:0] tx_q[$];
  logic [8:0] ack_q[$];
  int m_st;
  bit m_ab;
  logic [7:0] m_b;
  logic m_stop;
  logic [8:0] a_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decoder on o_uart_tx; a byte interrupted by reset is dropped.
  initial forever begin
    @(negedge clk);
    if (!rst && o_uart_tx === 1'b0) begin
      m_st = cyc;
      m_ab = 0;
      for (int i = 0; i < TICK / 2; i++) begin @(negedge clk); if (rst) m_ab = 1; end
      for (int k = 0; k < 9; k++) begin
        for (int i = 0; i < TICK; i++) begin @(negedge clk); if (rst) m_ab = 1; end
        if (k < 8) m_b[k] = o_uart_tx; else m_stop = o_uart_tx;
      end
      if (!m_ab) begin
        bytes_seen++;
        last_start = m_st;
        chk("tx_stop", m_stop, 1);
        if (tx_q.size() == 0) chk("tx_extra", 32'(tx_q.size()), 1);
        else chk("tx_byte", m_b, tx_q.pop_front());
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    if (o_ack === 1'b1) begin
      acks_seen++;
      last_ack = cyc;
      if (ack_q.size() == 0) chk("ack_extra", 32'(ack_q.size()), 1);
      else begin
        a_e = ack_q.pop_front();
        chk("o_data", o_data, a_e[7:0]);
        chk("o_err", o_err, a_e[8]);
      end
    end else if (o_err !== 1'b0) chk("err_no_ack", o_err, 0);
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (TICK) @(negedge clk);
    end
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int t = 0;
    while (bytes_seen < n && t < 5000) begin @(negedge clk); t++; end
    chk(tag, bytes_seen, n);
  endtask

  task automatic wait_acks(input int n, input string tag);
    int t = 0;
    while (acks_seen < n && t < 5000) begin @(negedge clk); t++; end
    chk(tag, acks_seen, n);
  endtask

  task automatic txn(input bit we, input logic [15:0] a, input logic [7:0] d,
                     input bit reply, input logic [7:0] r, input logic [8:0] exp, input bit hold);
    int b0, a0;
    b0 = bytes_seen;
    a0 = acks_seen;
    tx_q.push_back(we ? 8'h57 : 8'h52);
    tx_q.push_back(a[15:8]);
    tx_q.push_back(a[7:0]);
    if (we) tx_q.push_back(d);
    ack_q.push_back(exp);
    i_addr = a; i_data = d; i_we = we; i_cs = 1'b1;
    if (!we && reply) begin
      wait_bytes(b0 + 3, "rd_cmd_bytes");
      send_byte(r);
    end
    wait_acks(a0 + 1, "ack_seen");
    chk("frame_len", bytes_seen - b0, we ? 4 : 3);
    chk("txq_drained", 32'(tx_q.size()), 0);
    if (!hold) i_cs = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int b0, a0;
    repeat (5) @(negedge clk);
    chk("rst_tx", o_uart_tx, 1);
    chk("rst_ack", o_ack, 0);
    chk("rst_err", o_err, 0);
    chk("rst_data", o_data, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    // reset in the middle of a command byte
    b0 = bytes_seen; a0 = acks_seen;
    i_addr = 16'h5555; i_data = 8'h66; i_we = 1'b1; i_cs = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b1; i_cs = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_tx", o_uart_tx, 1);
    chk("midrst_ack", o_ack, 0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("midrst_no_bytes", bytes_seen, b0);
    chk("midrst_no_ack", acks_seen, a0);
    // write, then read with reply
    txn(1, 16'h1234, 8'hA5, 0, 8'h00, {1'b0, 8'h00}, 0);
    txn(0, 16'hBEEF, 8'h00, 1, 8'h3C, {1'b0, 8'h3C}, 0);
    // read timeout: ack lands 1000 clks after RWAIT entry, one clk after the AL start bit
    txn(0, 16'h0042, 8'h00, 0, 8'h00, {1'b1, 8'hFF}, 0);
    chk("tmo_latency", last_ack - last_start, TMO + 1);
    a0 = acks_seen;
    send_byte(8'h11);
    repeat (50) @(negedge clk);
    chk("late_reply_ignored", acks_seen, a0);
    txn(0, 16'h0042, 8'h00, 1, 8'h5A, {1'b0, 8'h5A}, 0);
    // held i_cs must not replay
    txn(1, 16'h0BAD, 8'h77, 0, 8'h00, {1'b0, 8'h5A}, 1);
    b0 = bytes_seen; a0 = acks_seen;
    repeat (2000) @(negedge clk);
    chk("hold_no_bytes", bytes_seen, b0);
    chk("hold_no_ack", acks_seen, a0);
    i_cs = 1'b0;
    @(negedge clk);
    txn(0, 16'h0BAD, 8'h00, 1, 8'hC3, {1'b0, 8'hC3}, 0);
    chk("rearm_one_frame", bytes_seen - b0, 3);
    // back-to-back write then read
    b0 = bytes_seen;
    txn(1, 16'h0000, 8'h01, 0, 8'h00, {1'b0, 8'hC3}, 0);
    txn(0, 16'hFFFF, 8'h00, 1, 8'h80, {1'b0, 8'h80}, 0);
    chk("b2b_bytes", bytes_seen - b0, 7);
    chk("b2b_data", o_data, 8'h80);
    repeat (50) @(negedge clk);
    chk("acks_drained", 32'(ack_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
